mem_wb_writeback_stage: RTL and testbench

//  Downstream neighbour of the memory stage: latches memory-stage results on memory_done and raises mem_wb_pipeline_valid.

---
 rtl/mem_wb_writeback_stage.sv | 150 +++++++++++++++
 tb/tb_mem_wb_writeback_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_writeback_stage.sv
// MEM/WB write-back stage: latches memory results, formats load data, drives the register-file write port.
// Optional bypass to execute enabled by defining MEM_WB_FORWARD_EN.
module mem_wb_writeback_stage #(
   parameter int XLEN   = 64,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memory_done,
   input  logic [XLEN-1:0]   loaded_data_in,
   input  logic [XLEN-1:0]   alu_data,
   input  logic [XLEN-1:0]   pc_plus4,
   input  logic [REG_AW-1:0] rd,
   input  logic              reg_write,
   input  logic              mem_to_reg,
   input  logic              jump_link,
   input  logic [1:0]        load_size,
   input  logic              load_unsigned,
   input  logic              flush,
   output logic              mem_wb_pipeline_valid,
   output logic              rf_write_en,
   output logic [REG_AW-1:0] rf_write_addr,
   output logic [XLEN-1:0]   rf_write_data,
   output logic              misaligned_load,
   output logic [CNT_W-1:0]  retired_count,
   output logic              fwd_valid,
   output logic [REG_AW-1:0] fwd_rd,
   output logic [XLEN-1:0]   fwd_data
);

   // state | meaning
   // IDLE  | latch empty, waiting for memory_done
   // WRITE | single cycle: register-file write strobe, retire count
   // DRAIN | result held valid until memory_done drops
   typedef enum logic [1:0] {IDLE, WRITE, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   load_data_q, alu_q, pc4_q;
   logic [REG_AW-1:0] rd_q;
   logic              reg_write_q, mem_to_reg_q, jump_link_q, unsigned_q;
   logic [1:0]        size_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              capture;
   logic [XLEN-1:0]   shifted;
   logic [XLEN-1:0]   load_fmt;
   logic              addr_mis;
   logic              mis;
   logic [XLEN-1:0]   wb_data;

   assign capture = (state_q == IDLE) && memory_done && !flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         load_data_q  <= '0;
         alu_q        <= '0;
         pc4_q        <= '0;
         rd_q         <= '0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         jump_link_q  <= 1'b0;
         unsigned_q   <= 1'b0;
         size_q       <= 2'b00;
         cnt_q        <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (capture) begin
            load_data_q  <= loaded_data_in;
            alu_q        <= alu_data;
            pc4_q        <= pc_plus4;
            rd_q         <= rd;
            reg_write_q  <= reg_write;
            mem_to_reg_q <= mem_to_reg;
            jump_link_q  <= jump_link;
            unsigned_q   <= load_unsigned;
            size_q       <= load_size;
         end
      end
   end

   // Offset selects the lane; shifting it down to bit 0 makes extension uniform.
   assign shifted = load_data_q >> {alu_q[2:0], 3'b000};

   always_comb begin
      load_fmt = load_data_q;
      addr_mis = 1'b0;
      case (size_q)
         2'b00: load_fmt = {{56{!unsigned_q && shifted[7]}}, shifted[7:0]};
         2'b01: begin
            load_fmt = {{48{!unsigned_q && shifted[15]}}, shifted[15:0]};
            addr_mis = alu_q[0];
         end
         2'b10: begin
            load_fmt = {{32{!unsigned_q && shifted[31]}}, shifted[31:0]};
            addr_mis = |alu_q[1:0];
         end
         default: begin
            load_fmt = load_data_q;
            addr_mis = |alu_q[2:0];
         end
      endcase
   end

   // Alignment only matters for instructions that actually take load data.
   assign mis     = mem_to_reg_q && addr_mis;
   assign wb_data = jump_link_q ? pc4_q : (mem_to_reg_q ? load_fmt : alu_q);

   always_comb begin
      state_d               = state_q;
      cnt_d                 = cnt_q;
      mem_wb_pipeline_valid = 1'b0;
      rf_write_en           = 1'b0;
      misaligned_load       = 1'b0;
      case (state_q)
         IDLE: begin
            if (capture) state_d = WRITE;
         end
         WRITE: begin
            mem_wb_pipeline_valid = 1'b1;
            rf_write_en     = reg_write_q && (rd_q != '0) && !mis && !flush;
            misaligned_load = mis;
            if (!flush) cnt_d = cnt_q + CNT_W'(1);
            state_d = DRAIN;
         end
         DRAIN: begin
            mem_wb_pipeline_valid = 1'b1;
            if (!memory_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign rf_write_addr = rd_q;
   assign rf_write_data = wb_data;
   assign retired_count = cnt_q;

`ifdef MEM_WB_FORWARD_EN
   assign fwd_valid = mem_wb_pipeline_valid && reg_write_q && (rd_q != '0) && !mis;
   assign fwd_rd    = rd_q;
   assign fwd_data  = wb_data;
`else
   assign fwd_valid = 1'b0;
   assign fwd_rd    = '0;
   assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_mem_wb_writeback_stage.sv
// Scoreboard bench for mem_wb_writeback_stage: directed cases plus randomized transactions
// checked against a byte-lane reference model.
module tb_mem_wb_writeback_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        memory_done;
   logic [63:0] loaded_data_in, alu_data, pc_plus4;
   logic [4:0]  rd;
   logic        reg_write, mem_to_reg, jump_link, load_unsigned, flush;
   logic [1:0]  load_size;
   logic        mem_wb_pipeline_valid, rf_write_en, misaligned_load;
   logic [4:0]  rf_write_addr;
   logic [63:0] rf_write_data;
   logic [63:0] retired_count;
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [63:0] fwd_data;

   mem_wb_writeback_stage dut (
      .clk(clk), .reset(reset), .memory_done(memory_done),
      .loaded_data_in(loaded_data_in), .alu_data(alu_data), .pc_plus4(pc_plus4),
      .rd(rd), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .jump_link(jump_link),
      .load_size(load_size), .load_unsigned(load_unsigned), .flush(flush),
      .mem_wb_pipeline_valid(mem_wb_pipeline_valid), .rf_write_en(rf_write_en),
      .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
      .misaligned_load(misaligned_load), .retired_count(retired_count),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [63:0] data;
      logic        mis;
      logic [63:0] cnt;
      logic        fv;
   } exp_t;

   exp_t        sbq[$];
   int          tests = 0;
   int          fails = 0;
   longint unsigned model_cnt = 0;
   int          writes_exp = 0;
   int          writes_seen = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Reference: pick the lane as a plain arithmetic slice, then extend.
   function automatic logic [63:0] model_load(input logic [63:0] d, input logic [63:0] a,
                                              input logic [1:0] sz, input logic uns);
      int          nb;
      int          off;
      logic [63:0] mask;
      logic [63:0] v;
      nb  = 1 << sz;
      off = int'(a % 8);
      if (nb == 8) return d;
      mask = (64'd1 << (nb * 8)) - 64'd1;
      v    = (d >> (off * 8)) & mask;
      if (!uns && v[nb*8-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic logic model_mis(input logic [63:0] a, input logic [1:0] sz);
      return (int'(a % 8) % (1 << sz)) != 0;
   endfunction

   // Monitor: pops one expectation at the first valid cycle of every result.
   initial begin : monitor
      logic prev_valid;
      exp_t e;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (rf_write_en === 1'b1) writes_seen++;
         if (mem_wb_pipeline_valid === 1'b1 && !prev_valid) begin
            if (sbq.size() == 0) begin
               chk("unexpected_result", 64'd1, 64'd0);
            end else begin
               e = sbq.pop_front();
               chk("rf_write_en", {63'd0, rf_write_en}, {63'd0, e.we});
               if (e.we) begin
                  chk("rf_write_addr", {59'd0, rf_write_addr}, {59'd0, e.addr});
                  chk("rf_write_data", rf_write_data, e.data);
               end
               chk("misaligned_load", {63'd0, misaligned_load}, {63'd0, e.mis});
               chk("retired_before", retired_count, e.cnt);
`ifdef MEM_WB_FORWARD_EN
               chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, e.fv});
               if (e.fv) begin
                  chk("fwd_rd", {59'd0, fwd_rd}, {59'd0, e.addr});
                  chk("fwd_data", fwd_data, e.data);
               end
`else
               chk("fwd_tied", {fwd_valid, fwd_rd, fwd_data[57:0]}, 64'd0);
`endif
            end
         end
         prev_valid = mem_wb_pipeline_valid;
      end
   end

   task automatic idle_inputs();
      memory_done = 1'b0; flush = 1'b0;
      loaded_data_in = '0; alu_data = '0; pc_plus4 = '0; rd = '0;
      reg_write = 1'b0; mem_to_reg = 1'b0; jump_link = 1'b0;
      load_size = 2'b00; load_unsigned = 1'b0;
   endtask

   // hold = extra DRAIN edges with memory_done still high.
   task automatic run_txn(input logic [63:0] ld, input logic [63:0] alu, input logic [63:0] pc4,
                          input logic [4:0] rdv, input logic rw, input logic m2r, input logic jl,
                          input logic [1:0] sz, input logic uns, input logic fl_w, input int hold);
      exp_t        e;
      logic        mis;
      logic [63:0] wbv;
      mis  = m2r && model_mis(alu, sz);
      wbv  = jl ? pc4 : (m2r ? model_load(ld, alu, sz, uns) : alu);
      e.we   = rw && (rdv != 0) && !mis && !fl_w;
      e.addr = rdv;
      e.data = wbv;
      e.mis  = mis;
      e.cnt  = model_cnt;
      e.fv   = rw && (rdv != 0) && !mis;
      sbq.push_back(e);

      @(posedge clk); #1;
      loaded_data_in = ld; alu_data = alu; pc_plus4 = pc4; rd = rdv;
      reg_write = rw; mem_to_reg = m2r; jump_link = jl; load_size = sz;
      load_unsigned = uns; memory_done = 1'b1; flush = 1'b0;
      @(posedge clk); #1;
      chk("valid_write", {63'd0, mem_wb_pipeline_valid}, 64'd1);
      memory_done = (hold > 0);
      flush = fl_w;
      loaded_data_in = ~ld; alu_data = ~alu; rd = ~rdv;
      @(posedge clk); #1;
      if (!fl_w) model_cnt++;
      if (e.we) writes_exp++;
      flush = 1'($urandom_range(0, 1));
      chk("valid_drain", {63'd0, mem_wb_pipeline_valid}, 64'd1);
      chk("we_drain", {63'd0, rf_write_en}, 64'd0);
      chk("retired_after", retired_count, model_cnt);
      for (int i = 1; i < hold; i++) begin
         @(posedge clk); #1;
         chk("drain_hold", {63'd0, mem_wb_pipeline_valid}, 64'd1);
      end
      memory_done = 1'b0;
      flush = 1'b0;
      @(posedge clk); #1;
      chk("valid_drop", {63'd0, mem_wb_pipeline_valid}, 64'd0);
   endtask

   initial begin : stim
      logic [63:0] ld, alu;
      logic [1:0]  sz;
      logic        m2r, jl;
      idle_inputs();
      reset = 1'b1;
      #12;
      chk("rst_valid", {63'd0, mem_wb_pipeline_valid}, 64'd0);
      chk("rst_we", {63'd0, rf_write_en}, 64'd0);
      chk("rst_count", retired_count, 64'd0);
      chk("rst_misc", {misaligned_load, rf_write_addr, rf_write_data[57:0]}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      run_txn(64'h1122334455667788, 64'h1000, 64'h0, 5'd5, 1, 1, 0, 2'b11, 0, 0, 0);
      chk("count_after_ld", retired_count, 64'd1);
      run_txn(64'h0000000080000000, 64'h1003, 64'h0, 5'd6, 1, 1, 0, 2'b00, 0, 0, 0);
      run_txn(64'h0000000080000000, 64'h1003, 64'h0, 5'd6, 1, 1, 0, 2'b00, 1, 0, 0);
      run_txn(64'hFFFF0000FFFF0000, 64'h1001, 64'h0, 5'd8, 1, 1, 0, 2'b01, 0, 0, 0);
      run_txn(64'h0, 64'hABCD, 64'h0, 5'd0, 1, 0, 0, 2'b00, 0, 0, 0);
      run_txn(64'h55, 64'h1000, 64'h2004, 5'd1, 1, 1, 1, 2'b11, 0, 0, 0);
      run_txn(64'h0, 64'h77, 64'h0, 5'd9, 1, 0, 0, 2'b00, 0, 0, 3);
      run_txn(64'h0, 64'h78, 64'h0, 5'd10, 1, 0, 0, 2'b00, 0, 1, 0);
      run_txn(64'h0, 64'h1234, 64'h0, 5'd7, 1, 0, 0, 2'b00, 0, 0, 1);

      // memory_done while flushing in IDLE captures nothing
      @(posedge clk); #1;
      memory_done = 1'b1; flush = 1'b1; alu_data = 64'h99; rd = 5'd3; reg_write = 1'b1;
      @(posedge clk); #1;
      chk("flush_idle_valid", {63'd0, mem_wb_pipeline_valid}, 64'd0);
      idle_inputs();

      // reset mid-WRITE: result lost, outputs drop immediately
      @(posedge clk); #1;
      alu_data = 64'h42; rd = 5'd4; reg_write = 1'b1; memory_done = 1'b1;
      @(posedge clk); #1;
      memory_done = 1'b0;
      chk("pre_reset_valid", {63'd0, mem_wb_pipeline_valid}, 64'd1);
      reset = 1'b1;
      #1;
      model_cnt = 0;
      chk("reset_valid", {63'd0, mem_wb_pipeline_valid}, 64'd0);
      chk("reset_we", {63'd0, rf_write_en}, 64'd0);
      chk("reset_count", retired_count, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
      run_txn(64'h0, 64'h4321, 64'h0, 5'd11, 1, 0, 0, 2'b00, 0, 0, 0);

      for (int n = 0; n < 60; n++) begin
         ld  = {$urandom, $urandom};
         alu = {$urandom, $urandom};
         jl  = ($urandom_range(0, 4) == 0);
         m2r = jl ? 1'b0 : 1'($urandom_range(0, 1));
         sz  = m2r ? 2'($urandom_range(0, 3)) : 2'b00;
         if (m2r && $urandom_range(0, 2) != 0) alu = alu & ~((64'd1 << sz) - 64'd1);
         run_txn(ld, alu, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 3) != 0), m2r, jl, sz, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
      end

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", 64'(sbq.size()), 64'd0);
      chk("write_count", 64'(writes_seen), 64'(writes_exp));
      chk("final_count", retired_count, model_cnt);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
